// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bundle: two requester handshakes plus the registered register-file write port.
// The arbiter takes the slave modport; requesters and the register file take the master side.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          last_grant;
    logic          busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  WE3, A3, WD3, last_grant, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output WE3, A3, WD3, last_grant, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter feeding the register-file write port (WE3/A3/WD3).
// Define ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic   [1:0] req_valid;
    entry_t       req_entry [2];

    logic   [1:0] buf_full;
    entry_t       buf_q     [2];

    logic   [1:0] grant;
    logic   [1:0] ready;
    logic   [1:0] load;
    entry_t       sel_entry;

    logic          we3_q;
    logic [AW-1:0] a3_q;
    logic [DW-1:0] wd3_q;
    logic          last_grant_q;

    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign req_entry[0] = '{addr: bus.req0_addr, data: bus.req0_data};
    assign req_entry[1] = '{addr: bus.req1_addr, data: bus.req1_data};

    // Grant depends only on registered state, which keeps every ready free of input paths.
    always_comb begin
        grant = 2'b00;
        if (buf_full == 2'b11) begin
`ifdef ARB_RR_EN
            if (last_grant_q) grant[0] = 1'b1;
            else              grant[1] = 1'b1;
`else
            grant[0] = 1'b1;
`endif
        end else begin
            grant = buf_full;
        end
    end

    always_comb begin
        ready = ~buf_full | grant;
        for (int n = 0; n < 2; n++) begin
            load[n] = req_valid[n] & ready[n] & (req_entry[n].addr != '0);
        end
        sel_entry = grant[1] ? buf_q[1] : buf_q[0];
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 2'b00;
        end else begin
            buf_full <= load | (buf_full & ~grant);
        end
    end

    // NOTE: payload registers carry no reset; buf_full qualifies them, so stale contents never issue.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (load[n]) buf_q[n] <= req_entry[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q        <= 1'b0;
            a3_q         <= '0;
            wd3_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            we3_q <= |grant;
            if (|grant) begin
                a3_q         <= sel_entry.addr;
                wd3_q        <= sel_entry.data;
                last_grant_q <= grant[1];
            end
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.WE3        = we3_q;
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd3_q;
    assign bus.last_grant = last_grant_q;
    assign bus.busy       = (|buf_full) | we3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and an observed register-file image.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: pending entry per requester, the port contents, and who went last.
    bit            m_full [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    bit            m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    bit            m_last;
    logic [DW-1:0] m_rf   [32];
    logic [DW-1:0] obs_rf [32];

    logic [AW-1:0] iss_addr [$];
    logic [DW-1:0] iss_data [$];
    logic [7:0]    we_hist;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_full[0] = 0;
        m_full[1] = 0;
        m_we      = 0;
        m_a3      = '0;
        m_wd3     = '0;
        m_last    = 1;
    endtask

    // Which pending entry leaves for the port next (-1 when nothing is pending).
    function automatic int m_winner();
        if (m_full[0] && m_full[1]) begin
`ifdef ARB_RR_EN
            return m_last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    // One clock: drive requests, check readys, clock, then check the port against the model.
    task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output bit acc0, output bit acc1);
        int            w;
        bit            rdy [2];
        bit            vv  [2];
        logic [AW-1:0] aa  [2];
        logic [DW-1:0] dd  [2];
        bit            port_we;
        logic [AW-1:0] port_a;
        logic [DW-1:0] port_d;
        vv[0] = v0; aa[0] = a0; dd[0] = d0;
        vv[1] = v1; aa[1] = a1; dd[1] = d1;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        w = m_winner();
        for (int n = 0; n < 2; n++) rdy[n] = !m_full[n] || (w == n);
        check("req0_ready", bus.req0_ready, rdy[0]);
        check("req1_ready", bus.req1_ready, rdy[1]);
        port_we = bus.WE3;
        port_a  = bus.A3;
        port_d  = bus.WD3;
        @(posedge clk);
        if (port_we) obs_rf[port_a] = port_d;
        if (m_we) m_rf[m_a3] = m_wd3;
        if (w >= 0) begin
            m_we   = 1;
            m_a3   = m_addr[w];
            m_wd3  = m_data[w];
            m_last = w[0];
        end else begin
            m_we = 0;
        end
        for (int n = 0; n < 2; n++) begin
            if (vv[n] && rdy[n] && aa[n] != '0) begin
                m_full[n] = 1;
                m_addr[n] = aa[n];
                m_data[n] = dd[n];
            end else if (w == n) begin
                m_full[n] = 0;
            end
        end
        acc0 = vv[0] && rdy[0];
        acc1 = vv[1] && rdy[1];
        #1;
        check("WE3", bus.WE3, m_we);
        check("A3", bus.A3, m_a3);
        check("WD3", bus.WD3, m_wd3);
        check("last_grant", bus.last_grant, m_last);
        check("busy", bus.busy, m_full[0] || m_full[1] || m_we);
        check("we3_addr0", bus.WE3 && bus.A3 == '0, 0);
        we_hist = {we_hist[6:0], bus.WE3};
        if (bus.WE3) begin
            iss_addr.push_back(bus.A3);
            iss_data.push_back(bus.WD3);
        end
    endtask

    task automatic idle(input int cycles);
        bit a0, a1;
        for (int i = 0; i < cycles; i++) step(0, '0, '0, 0, '0, '0, a0, a1);
    endtask

    task automatic do_reset();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        reset = 1;
        m_reset();
        #10;
        reset = 0;
        @(posedge clk);
        #1;
        iss_addr.delete();
        iss_data.delete();
        we_hist = '0;
    endtask

    bit            acc [2];
    bit            rv  [2];
    logic [AW-1:0] ra  [2];
    logic [DW-1:0] rd  [2];
    int            exp_seq [4];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            obs_rf[i] = '0;
        end
        bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
        reset = 1;
        m_reset();
        #12;
        reset = 0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_WE3", bus.WE3, 0);
        check("rst_A3", bus.A3, 0);
        check("rst_WD3", bus.WD3, 0);
        check("rst_last_grant", bus.last_grant, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_req0_ready", bus.req0_ready, 1);
        check("rst_req1_ready", bus.req1_ready, 1);

        // Single write
        step(1, 5'd5, 32'hDEADBEEF, 0, '0, '0, acc[0], acc[1]);
        check("single_accept", acc[0], 1);
        check("single_buffered_we", bus.WE3, 0);
        check("single_buffered_busy", bus.busy, 1);
        idle(1);
        check("single_we", bus.WE3, 1);
        check("single_a3", bus.A3, 5);
        check("single_wd3", bus.WD3, 32'hDEADBEEF);
        idle(1);
        check("single_we_drop", bus.WE3, 0);
        check("single_busy_drop", bus.busy, 0);

        // Register 0 writes complete the handshake and vanish
        step(0, '0, '0, 1, 5'd0, 32'h1234, acc[0], acc[1]);
        check("r0_accept", acc[1], 1);
        check("r0_busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("r0_we", bus.WE3, 0);
            check("r0_busy_idle", bus.busy, 0);
        end

        // Contention from reset
        do_reset();
`ifdef ARB_RR_EN
        exp_seq = '{1, 2, 1, 2};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, acc[0], acc[1]);
`ifndef ARB_RR_EN
            if (i < 3) check("fixed_req1_blocked", bus.req1_ready, 0);
`endif
        end
        idle(4);
        check("contention_count", iss_addr.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_addr.size()) check("contention_a3_seq", iss_addr[i], exp_seq[i]);
        end

        // Back-to-back stream from requester 0
        iss_addr.delete();
        iss_data.delete();
        we_hist = '0;
        for (int i = 0; i < 4; i++) begin
            step(1, AW'(3 + i), 32'hC0DE_0000 + i, 0, '0, '0, acc[0], acc[1]);
            check("stream_accept", acc[0], 1);
        end
        idle(3);
        check("stream_we_pattern", {1'b0, we_hist[6:0]}, 8'b0011_1100);
        check("stream_count", iss_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < iss_addr.size()) check("stream_a3_seq", iss_addr[i], 3 + i);
        end

        // Both requesters target the same register
        do_reset();
        step(1, 5'd7, 32'hA, 1, 5'd7, 32'hB, acc[0], acc[1]);
        idle(3);
        check("same_count", iss_data.size(), 2);
        if (iss_data.size() >= 2) begin
            check("same_first", iss_data[0], 32'hA);
            check("same_second", iss_data[1], 32'hB);
        end
        check("same_rf7", obs_rf[7], 32'hB);

        // Reset in the middle of traffic
        do_reset();
        step(1, 5'd8, 32'h88, 1, 5'd9, 32'h99, acc[0], acc[1]);
        step(1, 5'd10, 32'hAA, 1, 5'd9, 32'h99, acc[0], acc[1]);
        check("midrst_pre_we", bus.WE3, 1);
        check("midrst_pre_busy", bus.busy, 1);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        #4;
        reset = 1;
        m_reset();
        #1;
        check("midrst_WE3", bus.WE3, 0);
        check("midrst_A3", bus.A3, 0);
        check("midrst_WD3", bus.WD3, 0);
        check("midrst_req0_ready", bus.req0_ready, 1);
        check("midrst_req1_ready", bus.req1_ready, 1);
        check("midrst_busy", bus.busy, 0);
        #3;
        reset = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("midrst_no_stale", bus.WE3, 0);
        end

        // Randomized traffic; a stalled request is held until accepted
        rv[0] = 0;
        rv[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rv[n]) begin
                    rv[n] = ($urandom_range(0, 99) < 65);
                    ra[n] = AW'($urandom_range(0, 31));
                    rd[n] = $urandom;
                end
            end
            step(rv[0], ra[0], rd[0], rv[1], ra[1], rd[1], acc[0], acc[1]);
            for (int n = 0; n < 2; n++) if (acc[n]) rv[n] = 0;
        end
        idle(4);
        for (int r = 0; r < 32; r++) check("rand_rf", obs_rf[r], m_rf[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
